// File: rtl/bs_select_controller_db_if.sv
// Bus bundle for the double-buffered bitstream selector.
//
// Handshake semantics:
//   cfg_we/cfg_ready: a shadow-table write happens on the rising edge where
//   both are high. cfg_ready is registered and low while a swap is armed.
//   swap_req and frame_sync are single-cycle pulses sampled on the rising edge.
//   swap_done is high for exactly the cycle after a shadow->active copy.
//   dbg_state mirrors the controller FSM (0 = IDLE, 1 = ARMED).
interface bs_select_controller_db_if #(
  parameter int BS            = 8,
  parameter int NUM_BS        = 256,
  parameter int NUM_BS_SELECT = 8,
  parameter int BS_SELECT     = 3,
  parameter int CNT_W         = 8
) ();
  logic [NUM_BS-1:0]        bs_in;
  logic                     cfg_we;
  logic [BS_SELECT-1:0]     cfg_ch;
  logic [NUM_BS_SELECT-1:0] cfg_sel;
  logic                     cfg_en;
  logic                     cfg_ready;
  logic                     swap_req;
  logic                     frame_sync;
  logic                     swap_done;
  logic [CNT_W-1:0]         swap_cnt;
  logic [BS-1:0]            bs_out;
  logic                     dbg_state;

  modport master (
    output bs_in, cfg_we, cfg_ch, cfg_sel, cfg_en, swap_req, frame_sync,
    input  cfg_ready, swap_done, swap_cnt, bs_out, dbg_state
  );

  modport slave (
    input  bs_in, cfg_we, cfg_ch, cfg_sel, cfg_en, swap_req, frame_sync,
    output cfg_ready, swap_done, swap_cnt, bs_out, dbg_state
  );
endinterface

// File: rtl/bs_select_controller_db.sv
// Double-buffered bitstream selector: each output channel picks one of the
// broadcast bitstreams through an active selection table. A shadow table is
// written over the config port and copied into the active table only at a
// frame boundary after a swap request, so selections never change mid-frame.
module bs_select_controller_db #(
  parameter int BS            = 8,
  parameter int NUM_BS        = 256,
  parameter int NUM_BS_SELECT = 8,
  parameter int BS_SELECT     = 3,
  parameter int CNT_W         = 8
) (
  input logic                    clk,
  input logic                    rst,
  bs_select_controller_db_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t                   state;
  logic                     cfg_ready_q;
  logic                     swap_done_q;
  logic [CNT_W-1:0]         swap_cnt_q;
  logic [BS-1:0]            bs_out_q;

  logic [NUM_BS_SELECT-1:0] shd_sel [BS];
  logic [NUM_BS_SELECT-1:0] act_sel [BS];
  logic [BS-1:0]            shd_en;
  logic [BS-1:0]            act_en;

  logic [BS_SELECT-1:0]     wr_ch;
  logic                     do_copy;
  logic                     wr_ok;

  assign wr_ch = bus.cfg_ch;

  // Copy happens on a frame boundary when a swap is armed or requested this
  // very cycle; writes land only while the shadow is not frozen.
  always_comb begin
    do_copy = bus.frame_sync && ((state == ARMED) || bus.swap_req);
    wr_ok   = bus.cfg_we && cfg_ready_q && (32'(wr_ch) < BS);
  end

  // Shadow table: written from the config port. A copy on the same edge
  // still takes the pre-write contents because both are non-blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        shd_sel[i] <= NUM_BS_SELECT'(i % NUM_BS);
      end
      shd_en <= '0;
    end else if (wr_ok) begin
      shd_sel[wr_ch] <= bus.cfg_sel;
      shd_en[wr_ch]  <= bus.cfg_en;
    end
  end

  // Swap controller FSM: owns the active table, cfg_ready, swap_done and the
  // completed-copy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cfg_ready_q <= 1'b1;
      swap_done_q <= 1'b0;
      swap_cnt_q  <= '0;
      for (int i = 0; i < BS; i++) begin
        act_sel[i] <= NUM_BS_SELECT'(i % NUM_BS);
      end
      act_en <= '0;
    end else begin
      swap_done_q <= do_copy;
      if (do_copy) begin
        act_sel    <= shd_sel;
        act_en     <= shd_en;
        swap_cnt_q <= swap_cnt_q + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          // A request coinciding with frame_sync copies immediately.
          if (bus.swap_req && !bus.frame_sync) begin
            state       <= ARMED;
            cfg_ready_q <= 1'b0;
          end
        end
        ARMED: begin
          // Further requests are ignored; only the frame boundary matters.
          if (bus.frame_sync) begin
            state       <= IDLE;
            cfg_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: register each channel's selected bitstream through the
  // current active table; disabled channels and out-of-range indices give 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bs_out_q <= '0;
    end else begin
      for (int i = 0; i < BS; i++) begin
        bs_out_q[i] <= act_en[i] && (32'(act_sel[i]) < NUM_BS) &&
                       bus.bs_in[act_sel[i]];
      end
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.swap_done = swap_done_q;
  assign bus.swap_cnt  = swap_cnt_q;
  assign bus.bs_out    = bs_out_q;
  assign bus.dbg_state = state;

endmodule
